// File: rtl/hermes_input_buffer.sv
// Credit-based Hermes router input port: flit FIFO plus a packet-framing FSM that
// requests a route per packet and streams header, size and payload to the granted output.
module hermes_input_buffer #(
  parameter int unsigned FLIT_SIZE   = 32,
  parameter int unsigned BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 req_o,
  input  logic                 ack_h_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 data_av_o,
  input  logic                 data_ack_i,
  output logic                 sender_o
);

  localparam int unsigned PtrW = $clog2(BUFFER_SIZE);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(BUFFER_SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StHeader,
    StSize,
    StPayload
  } state_e;

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];

  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [FLIT_SIZE-1:0] remaining_q, remaining_d;
  state_e               state_q, state_d;

  logic not_empty;
  logic push;
  logic pop;

  assign not_empty = (count_q != '0);
  assign credit_o  = (count_q != CntFull);
  assign push      = rx_i && credit_o;
  assign pop       = data_av_o && data_ack_i;
  assign data_o    = mem[rd_ptr_q];
  assign sender_o  = (state_q == StHeader) || (state_q == StSize) || (state_q == StPayload);

  // Storage is not reset; a flit written to an empty FIFO is visible on data_o right away.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    req_o       = 1'b0;
    data_av_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (not_empty) begin
          state_d = StReq;
        end
      end
      StReq: begin
        req_o = 1'b1;
        if (ack_h_i) begin
          state_d = StHeader;
        end
      end
      StHeader: begin
        data_av_o = not_empty;
        if (not_empty && data_ack_i) begin
          state_d = StSize;
        end
      end
      StSize: begin
        data_av_o = not_empty;
        if (not_empty && data_ack_i) begin
          remaining_d = data_o;
          // A zero-length packet ends with its size flit.
          state_d     = (data_o == '0) ? StIdle : StPayload;
        end
      end
      StPayload: begin
        data_av_o = not_empty;
        if (not_empty && data_ack_i) begin
          remaining_d = remaining_q - FLIT_SIZE'(1);
          if (remaining_q == FLIT_SIZE'(1)) begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      state_q     <= StIdle;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Directed bench for hermes_input_buffer: reset, framing, back-pressure, zero-size packets,
// pointer wrap with concurrent push/pop, and a stalled consumer.
module tb_hermes_input_buffer;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [31:0] din;
  logic        credit;
  logic        req;
  logic        ack_h;
  logic [31:0] dout;
  logic        data_av;
  logic        data_ack;
  logic        sender;

  int n_assert = 0;
  int n_fail   = 0;

  hermes_input_buffer #(
    .FLIT_SIZE  (32),
    .BUFFER_SIZE(8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rx_i      (rx),
    .data_i    (din),
    .credit_o  (credit),
    .req_o     (req),
    .ack_h_i   (ack_h),
    .data_o    (dout),
    .data_av_o (data_av),
    .data_ack_i(data_ack),
    .sender_o  (sender)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp5 [14];
  logic [31:0] v3;
  int push_idx, pop_idx, mcount, cyc;
  logic do_push, do_pop;

  initial begin
    rst_n = 1'b1; rx = 1'b0; din = '0; ack_h = 1'b0; data_ack = 1'b0;
    #2 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_credit", credit, 1'b1);
    chk("rst_req", req, 1'b0);
    chk("rst_av", data_av, 1'b0);
    chk("rst_sender", sender, 1'b0);

    // Reset mid-cycle with three flits queued
    rx = 1'b1;
    din = 32'h0000_0102; step();
    din = 32'h0000_0001; step();
    din = 32'h1111_0001; step();
    rx = 1'b0;
    chk("r1_count3", dut.count_q, 3);
    chk("r1_req_before", req, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("r1_credit", credit, 1'b1);
    chk("r1_req", req, 1'b0);
    chk("r1_av", data_av, 1'b0);
    chk("r1_sender", sender, 1'b0);
    chk("r1_count", dut.count_q, 0);
    #1 rst_n = 1'b1;
    step(); step(); step();
    chk("r1_no_req", req, 1'b0);

    // Single packet
    ack_h = 1'b1; data_ack = 1'b1;
    rx = 1'b1; din = 32'h0000_0102; step();
    chk("sp_req_early", req, 1'b0);
    din = 32'h0000_0002; step();
    chk("sp_req", req, 1'b1);
    din = 32'hAAAA_0001; step();
    chk("sp_hdr", dout, 32'h0000_0102);
    chk("sp_av_hdr", data_av, 1'b1);
    chk("sp_sender", sender, 1'b1);
    din = 32'hAAAA_0002; step();
    rx = 1'b0;
    chk("sp_size", dout, 32'h0000_0002);
    chk("sp_av_size", data_av, 1'b1);
    step();
    chk("sp_p1", dout, 32'hAAAA_0001);
    chk("sp_av_p1", data_av, 1'b1);
    step();
    chk("sp_p2", dout, 32'hAAAA_0002);
    chk("sp_av_p2", data_av, 1'b1);
    step();
    chk("sp_sender_end", sender, 1'b0);
    chk("sp_av_end", data_av, 1'b0);
    chk("sp_count_end", dut.count_q, 0);
    ack_h = 1'b0; data_ack = 1'b0;

    // Fill to capacity while the grant is withheld
    for (int i = 0; i < 8; i++) begin
      rx = 1'b1;
      din = (i == 0) ? 32'h0000_0506 : (i == 1) ? 32'h0000_0006 : 32'hB000_0000 + i;
      step();
    end
    chk("fu_credit0", credit, 1'b0);
    chk("fu_count8", dut.count_q, 8);
    chk("fu_req", req, 1'b1);
    din = 32'hDEAD_BEEF; step();
    rx = 1'b0;
    chk("fu_drop_count", dut.count_q, 8);
    chk("fu_drop_credit", credit, 1'b0);
    ack_h = 1'b1; step();
    ack_h = 1'b0;
    chk("fu_hdr", dout, 32'h0000_0506);
    data_ack = 1'b1; step();
    data_ack = 1'b0;
    chk("fu_credit1", credit, 1'b1);
    chk("fu_count7", dut.count_q, 7);
    for (int j = 1; j < 8; j++) begin
      v3 = (j == 1) ? 32'h0000_0006 : 32'hB000_0000 + j;
      chk("fu_drain", dout, v3);
      data_ack = 1'b1; step();
    end
    data_ack = 1'b0;
    chk("fu_end_count", dut.count_q, 0);
    chk("fu_end_sender", sender, 1'b0);

    // Zero-size packet followed by a one-flit packet
    ack_h = 1'b1; data_ack = 1'b1; rx = 1'b1;
    din = 32'h0000_0304; step();
    din = 32'h0000_0000; step();
    din = 32'h0000_0102; step();
    din = 32'h0000_0001; step();
    din = 32'h0000_C0DE; step();
    rx = 1'b0;
    chk("zs_sender", sender, 1'b0);
    chk("zs_av", data_av, 1'b0);
    chk("zs_req0", req, 1'b0);
    chk("zs_count", dut.count_q, 3);
    step();
    chk("zs_req1", req, 1'b1);
    step();
    chk("zs_hdr2", dout, 32'h0000_0102);
    chk("zs_sender2", sender, 1'b1);
    step();
    chk("zs_size2", dout, 32'h0000_0001);
    step();
    chk("zs_pay2", dout, 32'h0000_C0DE);
    step();
    chk("zs_end_count", dut.count_q, 0);
    chk("zs_end_sender", sender, 1'b0);
    chk("zs_ptr", dut.wr_ptr_q, 1);

    // Two size-5 packets streamed with continuous push and pop
    exp5[0] = 32'h0000_0607; exp5[1] = 32'h0000_0005;
    exp5[7] = 32'h0000_0809; exp5[8] = 32'h0000_0005;
    for (int k = 0; k < 5; k++) begin
      exp5[2 + k] = 32'hD000_0000 + k;
      exp5[9 + k] = 32'hE000_0000 + k;
    end
    push_idx = 0; pop_idx = 0; mcount = 0; cyc = 0;
    while (pop_idx < 14 && cyc < 60) begin
      chk("wr_count", dut.count_q, mcount);
      chk("wr_credit", credit, (mcount != 8));
      do_pop = data_av;
      if (do_pop) begin
        chk("wr_data", dout, exp5[pop_idx]);
        pop_idx++;
      end
      do_push = (push_idx < 14) && (mcount != 8);
      if (push_idx < 14) begin
        rx = 1'b1; din = exp5[push_idx];
      end else begin
        rx = 1'b0;
      end
      if (do_push) push_idx++;
      mcount = mcount + int'(do_push) - int'(do_pop);
      step();
      cyc++;
    end
    rx = 1'b0;
    chk("wr_all_popped", pop_idx, 14);
    chk("wr_end_count", dut.count_q, 0);
    chk("wr_wptr", dut.wr_ptr_q, 7);
    chk("wr_rptr", dut.rd_ptr_q, 7);
    chk("wr_sender", sender, 1'b0);

    // Stalled consumer with a second header already queued
    ack_h = 1'b1; data_ack = 1'b0; rx = 1'b1;
    din = 32'h0000_0203; step();
    din = 32'h0000_0003; step();
    din = 32'hF000_0001; step();
    din = 32'hF000_0002; step();
    din = 32'hF000_0003; step();
    din = 32'h0000_0405; step();
    din = 32'h0000_0000; step();
    rx = 1'b0;
    chk("st_count7", dut.count_q, 7);
    chk("st_av", data_av, 1'b1);
    data_ack = 1'b1; step(); step();
    chk("st_rem3", dut.remaining_q, 3);
    chk("st_p1", dout, 32'hF000_0001);
    step();
    chk("st_p2", dout, 32'hF000_0002);
    chk("st_rem2", dut.remaining_q, 2);
    data_ack = 1'b0; step();
    chk("st_hold_p2", dout, 32'hF000_0002);
    chk("st_hold_rem2", dut.remaining_q, 2);
    chk("st_hold_count", dut.count_q, 4);
    chk("st_req_a", req, 1'b0);
    data_ack = 1'b1; step();
    chk("st_p3", dout, 32'hF000_0003);
    chk("st_rem1", dut.remaining_q, 1);
    data_ack = 1'b0; step();
    chk("st_hold_rem1", dut.remaining_q, 1);
    chk("st_req_b", req, 1'b0);
    chk("st_sender", sender, 1'b1);
    data_ack = 1'b1; step();
    data_ack = 1'b0;
    chk("st_idle_sender", sender, 1'b0);
    chk("st_idle_req", req, 1'b0);
    chk("st_next_hdr", dout, 32'h0000_0405);
    step();
    chk("st_next_req", req, 1'b1);
    data_ack = 1'b1; step(); step(); step();
    chk("st_end_count", dut.count_q, 0);
    chk("st_end_sender", sender, 1'b0);
    data_ack = 1'b0; ack_h = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hermes_input_buffer.md
Name: hermes_input_buffer

Overview:
- Parametrised-depth, credit-based input port buffer for one Hermes router port, in front of routing/crossbar logic.
- Queues incoming flits and parses the Hermes packet framing: header flit (target address, X in bits 15:8, Y in bits 7:0), size flit (payload flit count), then payload.
- Raises a routing request per packet and streams flits to the granted output with flit-level handshake.
- Replaces the fixed-depth port buffer; depth and flit width are generic.

Parameters:
- FLIT_SIZE, 32, flit width in bits; minimum 20.
- BUFFER_SIZE, 8, FIFO depth in flits; power of two, at least 2.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- rx_i  input  1  upstream flit valid.
- data_i  input  FLIT_SIZE  upstream flit.
- credit_o  output  1  space available; 1 when count < BUFFER_SIZE.
- req_o  output  1  routing request; header flit is at FIFO head.
- ack_h_i  input  1  routing grant for the pending request.
- data_o  output  FLIT_SIZE  flit at FIFO head, combinational from storage.
- data_av_o  output  1  data_o is a valid flit for the granted output.
- data_ack_i  input  1  downstream consumed data_o; pops head.
- sender_o  output  1  packet in transfer (grant held).

Behaviour:
- Storage: BUFFER_SIZE x FLIT_SIZE array, rd_ptr and wr_ptr of log2(BUFFER_SIZE) bits wrapping modulo BUFFER_SIZE, and count of log2(BUFFER_SIZE)+1 bits.
- Push: rx_i && credit_o. A flit written at edge k is visible on data_o from edge k if FIFO was empty.
- rx_i while full is ignored and the flit is dropped (protocol violation, not stored).
- Pop: data_av_o && data_ack_i.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- credit_o = (count != BUFFER_SIZE), combinational from count.
- FSM states:
  - IDLE: count != 0 -> REQ.
  - REQ: req_o=1. ack_h_i -> HEADER. ack_h_i sampled only in REQ.
  - HEADER: data_av_o = (count != 0). Pop -> SIZE.
  - SIZE: data_av_o = (count != 0). Pop latches remaining = data_o (FLIT_SIZE bits, unsigned). If value is 0 -> IDLE, else -> PAYLOAD.
  - PAYLOAD: data_av_o = (count != 0). Pop decrements remaining. A pop with remaining == 1 -> IDLE.
- sender_o = state in {HEADER, SIZE, PAYLOAD}, registered via state.
- req_o and data_av_o are 0 outside the states listed above.
- Minimum latency: first push at edge k -> REQ at edge k+1 -> req_o high in cycle k+1.
- The next packet's header is never requested before the previous packet's last pop.
- Back-to-back packets: IDLE lasts one cycle between packets when flits are already buffered.
- data_ack_i while data_av_o=0 is ignored.
- Reset, asynchronous, at any time including mid-packet:
  - rd_ptr=wr_ptr=count=0, remaining=0, state IDLE.
  - credit_o=1, req_o=0, data_av_o=0, sender_o=0.
  - data_o = storage[0] (contents unreset; don't-care).
- Reset deassertion is synchronised externally.

Test Plan:
- Reset: assert rst_ni=0 mid-cycle with 3 flits queued -> immediately credit_o=1, req_o=0, data_av_o=0, sender_o=0. After release, no req_o without new flits.
- Single packet: push 0x00000102, 0x00000002, 0xAAAA0001, 0xAAAA0002 on consecutive cycles; ack_h_i=1 on first req_o; data_ack_i held 1.
  - Required: req_o high one cycle after first push.
  - Flits emitted in order on four consecutive data_av_o&&data_ack_i cycles.
  - sender_o falls after the fourth pop; state IDLE, count 0.
- Full/back-pressure: hold ack_h_i=0 and push BUFFER_SIZE=8 flits.
  - Required: credit_o=0 after 8th push. A 9th rx_i flit is dropped, count stays 8.
  - After grant and one pop, credit_o=1.
- Zero-size packet: header 0x00000304 then size 0x00000000, followed by a second packet.
  - Required: sender_o drops after the size-flit pop, with no payload pops.
  - Second header raises req_o two cycles later.
- Wrap-around with simultaneous push/pop: stream two packets of size 5 (14 flits) through depth 8 with data_ack_i=1 and rx_i continuous.
  - Required: all 14 flits delivered in order, and count never exceeds 8.
  - Push+pop cycles leave count unchanged; pointers wrap 7->0 correctly.
- Stalled consumer: toggle data_ack_i 1-0-1-0 during payload.
  - Required: pops only on data_ack_i=1 cycles. remaining decrements only on pops.
  - req_o for the next queued header is not asserted until the last payload flit pops.
